// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - multi-channel CDC synchronizer with per-channel debounce and edge pulses
module sync_debounce #(
    parameter int                NUM_CH     = 4,
    parameter int                NUM_FF     = 2,
    parameter logic [NUM_CH-1:0] INIT_VALUE = '0,
    parameter int                DB_CYCLES  = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_i,
    input  logic [NUM_CH-1:0] sig_i,
    output logic [NUM_CH-1:0] level_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic              any_o
);

    localparam int               CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [NUM_CH-1:0][NUM_FF-1:0] sft_q, sft_d;
    logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0]             level_q, level_d;
    logic [NUM_CH-1:0]             rise_q, rise_d;
    logic [NUM_CH-1:0]             fall_q, fall_d;
    logic [NUM_CH-1:0]             s;
    logic                          any_q, any_d;

    always_comb begin
        sft_d   = sft_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        s       = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            s[ch]     = sft_q[ch][NUM_FF-1];
            sft_d[ch] = {sft_q[ch][NUM_FF-2:0], sig_i[ch]};
            // Any sample matching the current level restarts qualification.
            if (s[ch] == level_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (tick_i) begin
                if (cnt_q[ch] == CNT_LAST) begin
                    level_d[ch] = s[ch];
                    cnt_d[ch]   = '0;
                    rise_d[ch]  = s[ch];
                    fall_d[ch]  = ~s[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + 1'b1;
                end
            end
        end
        any_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                sft_q[ch] <= {NUM_FF{INIT_VALUE[ch]}};
            end
            cnt_q   <= '0;
            level_q <= INIT_VALUE;
            rise_q  <= '0;
            fall_q  <= '0;
            any_q   <= 1'b0;
        end else begin
            sft_q   <= sft_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            any_q   <= any_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign any_o   = any_q;

endmodule

// File: tb/tb_sync_debounce.sv
// tb/tb_sync_debounce.sv - self-checking bench for sync_debounce (DB=4 directed/random, DB=1 random)
module tb_sync_debounce;

    localparam int         NCH   = 4;
    localparam int         NF    = 2;
    localparam int         DB    = 4;
    localparam logic [3:0] INITB = 4'b1010;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_a;
    logic [3:0] sig_a, sig_b;
    logic [3:0] level_a, rise_a, fall_a, level_b, rise_b, fall_b;
    logic       any_a, any_b;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int rise_cnt [NCH];

    // reference state for the DB=4 instance
    logic [3:0] a_pipe [NF];
    int         a_run  [NCH];
    logic [3:0] ea_lvl, ea_rise, ea_fall;
    logic       ea_any;

    // reference state for the DB=1 instance: level is the input sampled NF edges ago
    logic [3:0] b_hist [$];
    logic [3:0] eb_lvl, eb_rise, eb_fall;
    logic       eb_any;

    always #5 clk = ~clk;

    sync_debounce #(.NUM_CH(NCH), .NUM_FF(NF), .INIT_VALUE(4'b0000), .DB_CYCLES(DB)) u_db4 (
        .clk(clk), .rst(rst), .tick_i(tick_a), .sig_i(sig_a),
        .level_o(level_a), .rise_o(rise_a), .fall_o(fall_a), .any_o(any_a)
    );

    sync_debounce #(.NUM_CH(NCH), .NUM_FF(NF), .INIT_VALUE(INITB), .DB_CYCLES(1)) u_db1 (
        .clk(clk), .rst(rst), .tick_i(1'b1), .sig_i(sig_b),
        .level_o(level_b), .rise_o(rise_b), .fall_o(fall_b), .any_o(any_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_a();
        logic [3:0] s;
        ea_rise = '0;
        ea_fall = '0;
        if (rst) begin
            for (int i = 0; i < NF; i++) a_pipe[i] = '0;
            for (int c = 0; c < NCH; c++) a_run[c] = 0;
            ea_lvl = '0;
        end else begin
            s = a_pipe[NF-1];
            for (int i = NF - 1; i > 0; i--) a_pipe[i] = a_pipe[i-1];
            a_pipe[0] = sig_a;
            for (int c = 0; c < NCH; c++) begin
                if (s[c] == ea_lvl[c]) a_run[c] = 0;
                else if (tick_a) begin
                    a_run[c]++;
                    if (a_run[c] == DB) begin
                        ea_lvl[c]  = s[c];
                        ea_rise[c] = s[c];
                        ea_fall[c] = ~s[c];
                        a_run[c]   = 0;
                    end
                end
            end
        end
        ea_any = |(ea_rise | ea_fall);
    endtask

    task automatic model_b();
        logic [3:0] nl;
        if (rst) begin
            b_hist  = {INITB, INITB, INITB};
            eb_lvl  = INITB;
            eb_rise = '0;
            eb_fall = '0;
        end else begin
            b_hist.push_front(sig_b);
            void'(b_hist.pop_back());
            nl      = b_hist[NF];
            eb_rise = nl & ~eb_lvl;
            eb_fall = ~nl & eb_lvl;
            eb_lvl  = nl;
        end
        eb_any = |(eb_rise | eb_fall);
    endtask

    task automatic step();
        sig_b = 4'($urandom);
        @(posedge clk);
        edge_n++;
        model_a();
        model_b();
        @(negedge clk);
        for (int c = 0; c < NCH; c++) rise_cnt[c] += int'(rise_a[c]);
        chk("a_level", 32'(level_a), 32'(ea_lvl));
        chk("a_rise",  32'(rise_a),  32'(ea_rise));
        chk("a_fall",  32'(fall_a),  32'(ea_fall));
        chk("a_any",   32'(any_a),   32'(ea_any));
        chk("b_level", 32'(level_b), 32'(eb_lvl));
        chk("b_rise",  32'(rise_b),  32'(eb_rise));
        chk("b_fall",  32'(fall_b),  32'(eb_fall));
        chk("b_any",   32'(any_b),   32'(eb_any));
    endtask

    initial begin
        int k, exp_e, seen, flag;
        rst    = 1'b1;
        tick_a = 1'b1;
        sig_a  = '0;
        sig_b  = '0;
        for (int c = 0; c < NCH; c++) rise_cnt[c] = 0;

        // reset state
        step();
        step();
        chk("reset_level_a", 32'(level_a), 32'h0);
        chk("reset_level_b", 32'(level_b), 32'(INITB));
        rst = 1'b0;

        // single change on ch0 sampled at edge 10 -> accepted at edge 15 only
        while (edge_n < 9) step();
        sig_a[0] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            step();
            chk("t1_rise0",  32'(rise_a[0]),  32'(edge_n == 15));
            chk("t1_level0", 32'(level_a[0]), 32'(edge_n >= 15));
        end

        // bounce on ch1: 1,1,0,0,1,1,0,0 then hold 1
        for (int c = 0; c < NCH; c++) rise_cnt[c] = 0;
        for (int i = 0; i < 8; i++) begin
            sig_a[1] = ((i / 2) % 2) == 0;
            step();
        end
        sig_a[1] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            step();
            chk("t2_rise1_time", 32'(rise_a[1]), 32'(j == 5));
        end
        chk("t2_one_rise", 32'(rise_cnt[1]), 32'd1);

        // tick every 3rd edge on ch2: accept on 4th tick after s differs
        for (int c = 0; c < NCH; c++) rise_cnt[c] = 0;
        k     = edge_n + 1;
        seen  = 0;
        exp_e = 0;
        for (int e = k + 2; seen < DB; e++) begin
            if (e % 3 == 0) begin
                seen++;
                exp_e = e;
            end
        end
        sig_a[2] = 1'b1;
        for (int j = 0; j < 20; j++) begin
            tick_a = ((edge_n + 1) % 3) == 0;
            step();
            chk("t3_rise2_time", 32'(rise_a[2]), 32'(edge_n == exp_e));
        end
        chk("t3_one_rise", 32'(rise_cnt[2]), 32'd1);
        tick_a = 1'b1;

        // all channels fall together, then all rise together
        sig_a = 4'h0;
        flag  = 0;
        for (int j = 0; j < 10; j++) begin
            step();
            if (fall_a == 4'h7 && any_a) flag = 1;
        end
        chk("t4_prefall", 32'(flag), 32'd1);
        sig_a = 4'hF;
        flag  = 0;
        for (int j = 0; j < 10; j++) begin
            step();
            if (rise_a == 4'hF && any_a) flag = 1;
        end
        chk("t4_all_rise", 32'(flag), 32'd1);

        // reset with a pending change on ch3 at cnt=2
        sig_a = 4'h0;
        for (int j = 0; j < 10; j++) step();
        sig_a[3] = 1'b1;
        for (int j = 0; j < 4; j++) step();
        rst = 1'b1;
        step();
        chk("t5_rst_level", 32'(level_a), 32'h0);
        chk("t5_rst_rise",  32'(rise_a),  32'h0);
        rst = 1'b0;
        for (int j = 0; j < 8; j++) begin
            step();
            chk("t5_rise3",  32'(rise_a[3]),  32'(j == 5));
            chk("t5_level3", 32'(level_a[3]), 32'(j >= 5));
        end

        // random inputs and tick on the DB=4 instance; DB=1 instance random throughout
        for (int j = 0; j < 400; j++) begin
            sig_a  = 4'($urandom);
            if ($urandom_range(3) == 0) sig_a = 4'($urandom);
            else if (j % 7 != 0) sig_a = level_a ^ 4'($urandom_range(1) << $urandom_range(3));
            tick_a = 1'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
